// File: rtl/user_io_pkg.sv
// Shared constants, register offsets and FSM state type for the user_io GPIO controller.
package user_io_pkg;

    localparam int NUM_IO_DFLT = 38;

    localparam logic [7:0] OFF_OUT_LO = 8'h00;
    localparam logic [7:0] OFF_OUT_HI = 8'h04;
    localparam logic [7:0] OFF_OEB_LO = 8'h08;
    localparam logic [7:0] OFF_OEB_HI = 8'h0C;
    localparam logic [7:0] OFF_IN_LO  = 8'h10;
    localparam logic [7:0] OFF_IN_HI  = 8'h14;
    localparam logic [7:0] OFF_IE_LO  = 8'h18;
    localparam logic [7:0] OFF_IE_HI  = 8'h1C;
    localparam logic [7:0] OFF_IS_LO  = 8'h20;
    localparam logic [7:0] OFF_IS_HI  = 8'h24;

    localparam logic [31:0] OEB_RST = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // Expand Wishbone byte enables into a 32-bit bit mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/user_io_ctrl_sync.sv
// Two-flop synchroniser for asynchronous pad inputs plus a history flop
// that turns the synchronised value into a one-cycle rising-edge vector.
module io_sync_edge #(
    parameter int W = 38
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;
    logic [W-1:0] prev_q;

    // Synchroniser chain and previous-value flop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= {W{1'b0}};
            sync2_q <= {W{1'b0}};
            prev_q  <= {W{1'b0}};
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign sync_o = sync2_q;
    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/user_io_ctrl.sv
// Wishbone-slave GPIO controller for the 38 user pads: output/enable
// registers, synchronised inputs, rising-edge interrupt status and IRQ.
module user_io_ctrl
    import user_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_IO    = NUM_IO_DFLT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic [2:0]        user_irq
);

    localparam int HI_W = NUM_IO - 32;
    localparam int PAD  = 32 - HI_W;

    state_e          state_q;
    logic            ack_q;
    logic [31:0]     dat_q;
    logic [31:0]     out_lo_q, out_lo_d, oeb_lo_q, oeb_lo_d;
    logic [31:0]     ie_lo_q, ie_lo_d, is_lo_q, is_lo_d;
    logic [HI_W-1:0] out_hi_q, out_hi_d, oeb_hi_q, oeb_hi_d;
    logic [HI_W-1:0] ie_hi_q, ie_hi_d, is_hi_q, is_hi_d;

    logic [NUM_IO-1:0] sync_s;
    logic [NUM_IO-1:0] rise_s;
    logic              hit_s, acc_s, wr_s;
    logic [7:0]        off_s;
    logic [31:0]       mask_s, rdata_s, w1c_lo_s;
    logic [HI_W-1:0]   mask_hi_s, dat_hi_s, w1c_hi_s;
    logic              unused_s;

    io_sync_edge #(.W(NUM_IO)) u_sync (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .d_i    (io_in),
        .sync_o (sync_s),
        .rise_o (rise_s)
    );

    assign hit_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc_s     = hit_s & (state_q == ST_IDLE);
    assign wr_s      = acc_s & wbs_we_i;
    assign off_s     = {wbs_adr_i[7:2], 2'b00};
    assign mask_s    = sel_mask(wbs_sel_i);
    assign mask_hi_s = mask_s[HI_W-1:0];
    assign dat_hi_s  = wbs_dat_i[HI_W-1:0];
    assign unused_s  = ^wbs_adr_i[1:0];

    // Read mux over the current register state; unmapped offsets read zero.
    always_comb begin
        rdata_s = 32'h0;
        case (off_s)
            OFF_OUT_LO: rdata_s = out_lo_q;
            OFF_OUT_HI: rdata_s = {{PAD{1'b0}}, out_hi_q};
            OFF_OEB_LO: rdata_s = oeb_lo_q;
            OFF_OEB_HI: rdata_s = {{PAD{1'b0}}, oeb_hi_q};
            OFF_IN_LO:  rdata_s = sync_s[31:0];
            OFF_IN_HI:  rdata_s = {{PAD{1'b0}}, sync_s[NUM_IO-1:32]};
            OFF_IE_LO:  rdata_s = ie_lo_q;
            OFF_IE_HI:  rdata_s = {{PAD{1'b0}}, ie_hi_q};
            OFF_IS_LO:  rdata_s = is_lo_q;
            OFF_IS_HI:  rdata_s = {{PAD{1'b0}}, is_hi_q};
            default:    rdata_s = 32'h0;
        endcase
    end

    // Register next-state: byte-masked writes, W1C on status, edges win over clears.
    always_comb begin
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        oeb_lo_d = oeb_lo_q;
        oeb_hi_d = oeb_hi_q;
        ie_lo_d  = ie_lo_q;
        ie_hi_d  = ie_hi_q;
        w1c_lo_s = 32'h0;
        w1c_hi_s = {HI_W{1'b0}};
        if (wr_s) begin
            case (off_s)
                OFF_OUT_LO: out_lo_d = (out_lo_q & ~mask_s) | (wbs_dat_i & mask_s);
                OFF_OUT_HI: out_hi_d = (out_hi_q & ~mask_hi_s) | (dat_hi_s & mask_hi_s);
                OFF_OEB_LO: oeb_lo_d = (oeb_lo_q & ~mask_s) | (wbs_dat_i & mask_s);
                OFF_OEB_HI: oeb_hi_d = (oeb_hi_q & ~mask_hi_s) | (dat_hi_s & mask_hi_s);
                OFF_IE_LO:  ie_lo_d  = (ie_lo_q & ~mask_s) | (wbs_dat_i & mask_s);
                OFF_IE_HI:  ie_hi_d  = (ie_hi_q & ~mask_hi_s) | (dat_hi_s & mask_hi_s);
                OFF_IS_LO:  w1c_lo_s = wbs_dat_i & mask_s;
                OFF_IS_HI:  w1c_hi_s = dat_hi_s & mask_hi_s;
                default:    w1c_lo_s = 32'h0;
            endcase
        end else begin
            w1c_lo_s = 32'h0;
        end
        is_lo_d = (is_lo_q & ~w1c_lo_s) | rise_s[31:0];
        is_hi_d = (is_hi_q & ~w1c_hi_s) | rise_s[NUM_IO-1:32];
    end

    // Bus FSM with registered ack/read data, plus register file update.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            out_lo_q <= 32'h0;
            out_hi_q <= {HI_W{1'b0}};
            oeb_lo_q <= OEB_RST;
            oeb_hi_q <= OEB_RST[HI_W-1:0];
            ie_lo_q  <= 32'h0;
            ie_hi_q  <= {HI_W{1'b0}};
            is_lo_q  <= 32'h0;
            is_hi_q  <= {HI_W{1'b0}};
        end else begin
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
            oeb_lo_q <= oeb_lo_d;
            oeb_hi_q <= oeb_hi_d;
            ie_lo_q  <= ie_lo_d;
            ie_hi_q  <= ie_hi_d;
            is_lo_q  <= is_lo_d;
            is_hi_q  <= is_hi_d;
            case (state_q)
                ST_IDLE: begin
                    if (acc_s) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        dat_q   <= wbs_we_i ? 32'h0 : rdata_s;
                    end else begin
                        ack_q   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = {out_hi_q, out_lo_q};
    assign io_oeb    = {oeb_hi_q, oeb_lo_q};
    assign user_irq  = {2'b00, |({is_hi_q, is_lo_q} & {ie_hi_q, ie_lo_q})};

endmodule

// File: tb/tb_user_io_ctrl.sv
// Self-checking bench for user_io_ctrl: per-cycle behavioural model,
// directed vector table, hand-written corner sequences and random traffic.
module tb_user_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        ack;
    logic [37:0] io_in, io_out, io_oeb;
    logic [2:0]  irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    user_io_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (irq)
    );

    // Model: register bank indexed OUT=0, OEB=1, IN=2 (unused), IE=3, IS=4.
    logic [37:0] m_reg [5];
    logic [37:0] h0, h1, h2;   // io_in sampled 1, 2, 3 edges ago
    logic        m_ack;
    logic [31:0] m_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        logic [37:0] v;
        if (idx >= 6'd10) return 32'h0;
        v = (idx[5:1] == 5'd2) ? h1 : m_reg[idx[5:1]];
        return idx[0] ? {26'h0, v[37:32]} : v[31:0];
    endfunction

    task automatic model_edge();
        logic [37:0] rise, w1c;
        logic [31:0] m;
        logic [5:0]  idx;
        logic        acc;
        int          r;
        if (!rst_n) begin
            m_reg[0] = 38'h0;
            m_reg[1] = {38{1'b1}};
            m_reg[2] = 38'h0;
            m_reg[3] = 38'h0;
            m_reg[4] = 38'h0;
            h0 = 38'h0; h1 = 38'h0; h2 = 38'h0;
            m_ack = 1'b0;
            m_dat = 32'h0;
        end else begin
            rise = h1 & ~h2;
            w1c  = 38'h0;
            acc  = cyc && stb && (adr[31:8] == 24'h30_0000) && !m_ack;
            idx  = adr[7:2];
            m    = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            if (acc) begin
                if (!we) begin
                    m_dat = m_read(idx);
                end else begin
                    m_dat = 32'h0;
                    r = int'(idx) / 2;
                    if (idx < 6'd10 && r != 2) begin
                        if (r == 4)
                            w1c = idx[0] ? {dat_w[5:0] & m[5:0], 32'h0} : {6'h0, dat_w & m};
                        else if (idx[0])
                            m_reg[r][37:32] = (m_reg[r][37:32] & ~m[5:0]) | (dat_w[5:0] & m[5:0]);
                        else
                            m_reg[r][31:0] = (m_reg[r][31:0] & ~m) | (dat_w & m);
                    end
                end
            end
            m_reg[4] = (m_reg[4] & ~w1c) | rise;
            m_ack = acc;
            h2 = h1; h1 = h0; h0 = io_in;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("ack",    64'(ack),    64'(m_ack));
        chk("dat_o",  64'(dat_r),  64'(m_dat));
        chk("io_out", 64'(io_out), 64'(m_reg[0]));
        chk("io_oeb", 64'(io_oeb), 64'(m_reg[1]));
        chk("irq",    64'(irq),    64'({2'b00, |(m_reg[4] & m_reg[3])}));
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        cycle();
        n = 1;
        while (!ack && n < 4) begin
            cycle();
            n++;
        end
        chk("ack_latency", 64'(n), 64'd1);
        rd = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] rd;
        int          acks;
        int          b;

        tbl[0]  = '{1'b1, 32'h3000_0000, 32'hA5A5_5A5A, 4'b0101, 32'h0};
        tbl[1]  = '{1'b0, 32'h3000_0000, 32'h0,         4'b1111, 32'h00A5_005A};
        tbl[2]  = '{1'b1, 32'h3000_000C, 32'h0000_003F, 4'b1111, 32'h0};
        tbl[3]  = '{1'b0, 32'h3000_000C, 32'h0,         4'b1111, 32'h0000_003F};
        tbl[4]  = '{1'b1, 32'h3000_000C, 32'h0,         4'b1111, 32'h0};
        tbl[5]  = '{1'b0, 32'h3000_000C, 32'h0,         4'b1111, 32'h0};
        tbl[6]  = '{1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'b1111, 32'h0};
        tbl[7]  = '{1'b0, 32'h3000_0004, 32'h0,         4'b1111, 32'h0000_003F};
        tbl[8]  = '{1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'b1111, 32'h0};
        tbl[9]  = '{1'b0, 32'h3000_0010, 32'h0,         4'b1111, 32'h0};
        tbl[10] = '{1'b1, 32'h3000_0040, 32'h0000_1234, 4'b1111, 32'h0};
        tbl[11] = '{1'b0, 32'h3000_0040, 32'h0,         4'b1111, 32'h0};
        tbl[12] = '{1'b1, 32'h3000_0018, 32'hFFFF_FFFF, 4'b0000, 32'h0};
        tbl[13] = '{1'b0, 32'h3000_0018, 32'h0,         4'b1111, 32'h0};
        tbl[14] = '{1'b1, 32'h3000_0008, 32'h0,         4'b1000, 32'h0};
        tbl[15] = '{1'b0, 32'h3000_0008, 32'h0,         4'b1111, 32'h00FF_FFFF};

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_w = 32'h0; io_in = 38'h0;

        // Reset held for three clocks.
        repeat (3) cycle();
        chk("rst_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        chk("rst_out", 64'(io_out), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 16; i++) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
            if (!tbl[i].we) chk($sformatf("tbl_rd%0d", i), 64'(rd), 64'(tbl[i].exp));
        end
        chk("oeb_hi_zero", 64'(io_oeb[37:32]), 64'h0);
        chk("out_pattern", 64'(io_out), 64'(38'h3F_00A5_005A));

        // Pad 35 rising edge with IE_HI bit 3 enabled.
        bus(1'b1, 32'h3000_001C, 32'h0000_0008, 4'b1111, rd);
        io_in[35] = 1'b1;
        cycle(); chk("irq_e1", 64'(irq[0]), 64'h0);
        cycle(); chk("irq_e2", 64'(irq[0]), 64'h0);
        cycle(); chk("irq_e3", 64'(irq[0]), 64'h1);
        bus(1'b0, 32'h3000_0024, 32'h0, 4'b1111, rd);
        chk("is_hi_rd", 64'(rd), 64'h8);
        bus(1'b1, 32'h3000_0024, 32'h0000_0008, 4'b1111, rd);
        chk("irq_clr", 64'(irq[0]), 64'h0);

        // W1C on IS_LO[3] at the same edge the pad-3 edge lands: set wins.
        io_in[3] = 1'b1;
        cycle();
        cycle();
        bus(1'b1, 32'h3000_0020, 32'h0000_0008, 4'b1111, rd);
        bus(1'b0, 32'h3000_0020, 32'h0, 4'b1111, rd);
        chk("set_wins", 64'(rd & 32'h8), 64'h8);
        bus(1'b1, 32'h3000_0020, 32'h0000_0008, 4'b1111, rd);
        bus(1'b0, 32'h3000_0020, 32'h0, 4'b1111, rd);
        chk("w1c_clears", 64'(rd & 32'h8), 64'h0);

        // Out-of-window access is never acknowledged.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (ack) acks++;
        end
        chk("miss_acks", 64'(acks), 64'h0);
        cyc = 1'b0; stb = 1'b0;
        cycle();

        // Reset asserted while ack is high.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000;
        cycle();
        chk("ack_before_rst", 64'(ack), 64'h1);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        cycle();
        chk("rst_mid_ack", 64'(ack), 64'h0);
        chk("rst_mid_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        chk("rst_mid_out", 64'(io_out), 64'h0);
        rst_n = 1'b1;
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            sel   = 4'($urandom_range(0, 15));
            dat_w = $urandom;
            if ($urandom_range(0, 7) == 0)
                adr = $urandom;
            else
                adr = 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) begin
                b = int'($urandom_range(0, 37));
                io_in[b] = ~io_in[b];
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
